digit_scan_ctrl: RTL and testbench
==================================

Name: digit_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit seven-segment display.
- Sits directly upstream of the 2-to-4 enabled decoder: drives the decoder's 2-bit select and enable, and presents the active digit's 4-bit nibble and decimal point to the segment encoder.
- Adds per-digit dwell timing, an inter-digit blanking (anti-ghosting) interval and frame-coherent data latching.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit lit interval (1 kHz per digit at 100 MHz); must be ≥1
- BLANK_CYCLES, 1000, clk cycles with enable low between digits; 0 means no blank interval
- CNT_W, 17, width of the shared interval counter; must hold max(REFRESH_DIV, BLANK_CYCLES)-1

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  scan enable; when low, the display is dark
- digits  in  16  four hex digits; digits[3:0] = digit 0 (least significant), digits[15:12] = digit 3
- dp_in  in  4  decimal point per digit; bit i belongs to digit i
- sel  out  2  digit index to the decoder W input
- sel_en  out  1  to the decoder EN input; high only while a digit is lit
- nibble  out  4  hex value of the selected digit
- dp  out  1  decimal point of the selected digit
- frame_done  out  1  one-cycle pulse when digit 3's blank interval completes (sel wraps 3→0)

Behaviour:
- All outputs are registered.
- Reset values: sel=0, sel_en=0, nibble=0, dp=0, frame_done=0, state=IDLE, counter=0, frame latch=0.
- Reset is asynchronous and may assert in any state. Outputs go to their reset values immediately. Scanning resumes from IDLE after release.
- States: IDLE, SHOW, BLANK.
- IDLE:
  - sel_en=0, sel=0, counter=0.
  - When run=1: latch digits and dp_in into the frame latch, go to SHOW.
  - sel_en=1 appears the cycle after run is first sampled high.
- SHOW:
  - sel_en=1; nibble and dp come from the frame latch at index sel.
  - Counter increments each cycle; at counter==REFRESH_DIV-1, clear the counter and leave.
  - Exit goes to BLANK, or straight to the next digit when BLANK_CYCLES=0.
  - Each digit is lit for exactly REFRESH_DIV cycles.
- BLANK:
  - sel_en=0; sel, nibble and dp hold.
  - Counter runs to BLANK_CYCLES-1, then clears.
- Advance (end of BLANK, or end of SHOW when BLANK_CYCLES=0):
  - sel = sel+1 modulo 4, wrapping 3→0.
  - On the 3→0 wrap: frame_done pulses for one cycle, and the frame latch reloads from digits/dp_in in the same cycle.
  - Next state is SHOW.
- Frame coherence: changes on digits/dp_in mid-frame are not displayed until the next frame. No tearing within a frame.
- run deasserted in any state: next cycle goes to IDLE with sel_en=0 and sel=0. No frame_done pulse. Nothing is partially displayed afterwards.
- Timing: frame period = 4 × (REFRESH_DIV + BLANK_CYCLES) cycles.
- Exactly one digit is enabled at a time. sel never changes while sel_en=1.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: during SHOW, sel_en is forced low for digit i (i = 1..3) when the latched digit i and every higher-index latched digit are all 0 and their dp bits are all 0. Digit 0 is never blanked. Slot timing is unchanged, so frame period and frame_done are identical.
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Shared package scan_pkg:
  - state encoding (IDLE=2'b00, SHOW=2'b01, BLANK=2'b10)
  - NUM_DIGITS=4, SEL_W=2, NIBBLE_W=4
- One natural sub-module: scan_interval_cnt.
  - A terminal-count counter with clear and a runtime-selectable terminal value (REFRESH_DIV-1 or BLANK_CYCLES-1).
  - Outputs a done pulse.
  - Instantiated once, time-shared by SHOW and BLANK.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=2 unless stated):
- Reset, then run=1, digits=16'h1234 → from the cycle after run: sel=0, sel_en=1, nibble=4 for 4 cycles; then sel_en=0 for 2 cycles; then sel=1, nibble=3; …; sel=3, nibble=1; frame_done pulses once every 24 cycles.
- BLANK_CYCLES=0, digits=16'hABCD → sel_en stays high continuously; sel steps 0,1,2,3 every 4 cycles; nibble D,C,B,A; frame_done every 16 cycles.
- digits changed from 16'h1234 to 16'h5678 while sel=1 → remaining digits of that frame still show 3,2,1; the next frame shows 8,7,6,5.
- run dropped while sel=2 in SHOW → next cycle sel_en=0, sel=0, no frame_done; run reasserted → restarts at sel=0 with freshly latched digits.
- reset asserted mid-BLANK with sel=3 → all outputs zero asynchronously, before the next clk edge; no frame_done pulse afterwards.
- With LEADING_ZERO_BLANK_EN, digits=16'h0070, dp_in=0 → slots 0 and 1 lit (0, 7); slots 2 and 3 have sel_en=0; frame period is still 24 cycles.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the seven-segment digit scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;
    localparam int NIBBLE_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHOW  = 2'b01,
        BLANK = 2'b10
    } state_e;

    // Frame latch layout: element i is digit i (digit 0 least significant).
    typedef logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] frame_t;

    // Bit i set when digit i and every higher digit are zero with no decimal
    // point. Digit 0 is never flagged so a value of zero still shows "0".
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(
        input frame_t                  f,
        input logic [NUM_DIGITS-1:0]   p
    );
        logic all_zero;
        lead_zero_mask = '0;
        all_zero       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero          = all_zero && (f[i] == '0) && !p[i];
            lead_zero_mask[i] = all_zero;
        end
    endfunction

endpackage

// File: rtl/scan_interval_cnt.sv
// Terminal-count interval counter, time-shared between lit and blank slots.
// Latency: done is combinational on the current count; count updates each clk.
// Backpressure: none; en stalls counting, clr forces the count to zero.
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable
//   term       : terminal value; the count wraps to 0 after reaching it
//   done       : high in the cycle the count equals term while enabled
module scan_interval_cnt #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done = en && (cnt_q == term);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller with dwell, blanking
// and frame-coherent latching. Latency: outputs registered, sel_en rises one
// clk after run is sampled high. Backpressure: none; run low darkens display.
//
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   run         : scan enable
//   digits      : four hex digits, digits[3:0] is digit 0
//   dp_in       : decimal point per digit
//   sel, sel_en : decoder select and enable (enable only while a digit is lit)
//   nibble, dp  : value and decimal point of the selected digit
//   frame_done  : one-cycle pulse on the 3->0 wrap
//
// Optional build macro LEADING_ZERO_BLANK_EN: suppress sel_en for leading zero
// digits (1..3) without altering slot timing.
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]          dp_in,
    output logic [SEL_W-1:0]               sel,
    output logic                           sel_en,
    output logic [NIBBLE_W-1:0]            nibble,
    output logic                           dp,
    output logic                           frame_done
);

    localparam logic [CNT_W-1:0] SHOW_TERM  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_TERM =
        CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    frame_t                  frame_q, frame_d;
    logic [NUM_DIGITS-1:0]   fdp_q, fdp_d;
    logic                    sel_en_q, sel_en_d;
    logic [NIBBLE_W-1:0]     nibble_q, nibble_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic                    cnt_clr;
    logic                    cnt_en;
    logic [CNT_W-1:0]        cnt_term;
    logic                    cnt_done;
    logic                    advance;
    logic                    lit;
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]   lz_mask;
`endif

    scan_interval_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .term  (cnt_term),
        .done  (cnt_done)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        frame_d      = frame_q;
        fdp_d        = fdp_q;
        frame_done_d = 1'b0;
        advance      = 1'b0;
        cnt_en       = (state_q == SHOW) || (state_q == BLANK);
        cnt_term     = (state_q == SHOW) ? SHOW_TERM : BLANK_TERM;
        cnt_clr      = !run || (state_q == IDLE);

        if (!run) begin
            state_d = IDLE;
            sel_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_d = frame_t'(digits);
                    fdp_d   = dp_in;
                    sel_d   = '0;
                    state_d = SHOW;
                end
                SHOW: begin
                    if (cnt_done) begin
                        if (BLANK_CYCLES == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = BLANK;
                        end
                    end
                end
                BLANK: begin
                    if (cnt_done) begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = '0;
                end
            endcase
        end

        if (advance) begin
            state_d = SHOW;
            sel_d   = sel_q + SEL_W'(1);
            // New frame starts on the wrap; reload so the next frame is coherent.
            if (sel_q == SEL_W'(NUM_DIGITS - 1)) begin
                frame_done_d = 1'b1;
                frame_d      = frame_t'(digits);
                fdp_d        = dp_in;
            end
        end

        // Outputs are computed from next-state values so that registering
        // them keeps sel, sel_en and nibble aligned with the state register.
        lit = (state_d == SHOW);
`ifdef LEADING_ZERO_BLANK_EN
        lz_mask = lead_zero_mask(frame_d, fdp_d);
        lit     = lit && !lz_mask[sel_d];
`endif
        sel_en_d = lit;
        if (state_d == IDLE) begin
            nibble_d = '0;
            dp_d     = 1'b0;
        end else begin
            nibble_d = frame_d[sel_d];
            dp_d     = fdp_d[sel_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            frame_q      <= '0;
            fdp_q        <= '0;
            sel_en_q     <= 1'b0;
            nibble_q     <= '0;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            frame_q      <= frame_d;
            fdp_q        <= fdp_d;
            sel_en_q     <= sel_en_d;
            nibble_q     <= nibble_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign sel_en     = sel_en_q;
    assign nibble     = nibble_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: main instance REFRESH_DIV=4/BLANK=2,
// second instance with no blank interval.
module tb_digit_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [1:0]  sel;
    logic        sel_en;
    logic [3:0]  nibble;
    logic        dp;
    logic        frame_done;

    logic        run_nb;
    logic [15:0] digits_nb;
    logic [1:0]  sel_nb;
    logic        sel_en_nb;
    logic [3:0]  nibble_nb;
    logic        dp_nb;
    logic        frame_done_nb;

    int checks = 0;
    int errors = 0;
    logic [3:0] lzm;

    digit_scan_ctrl #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (2),
        .CNT_W        (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .digits     (digits),
        .dp_in      (dp_in),
        .sel        (sel),
        .sel_en     (sel_en),
        .nibble     (nibble),
        .dp         (dp),
        .frame_done (frame_done)
    );

    digit_scan_ctrl #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (0),
        .CNT_W        (3)
    ) dut_nb (
        .clk        (clk),
        .reset      (reset),
        .run        (run_nb),
        .digits     (digits_nb),
        .dp_in      (4'b0000),
        .sel        (sel_nb),
        .sel_en     (sel_en_nb),
        .nibble     (nibble_nb),
        .dp         (dp_nb),
        .frame_done (frame_done_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // One full frame of the main instance: 4 slots x (4 lit + 2 blank).
    // Entered with the outputs of slot 0 / cycle 0 already visible.
    task automatic check_frame(input logic [15:0] d, input logic [3:0] p, input logic fd0,
                               input int chg_k, input logic [15:0] chg_val, input logic [3:0] lz);
        for (int k = 0; k < 24; k++) begin
            int   s;
            logic lit;
            s   = k / 6;
            lit = ((k % 6) < 4) && !lz[s];
            chk("sel", k, 32'(sel), 32'(s));
            chk("sel_en", k, 32'(sel_en), 32'(lit));
            chk("nibble", k, 32'(nibble), 32'(d[s*4 +: 4]));
            chk("dp", k, 32'(dp), 32'(p[s]));
            chk("frame_done", k, 32'(frame_done), (k == 0) ? 32'(fd0) : 32'(0));
            if (k == chg_k) digits = chg_val;
            tick();
        end
    endtask

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        digits    = 16'h0000;
        dp_in     = 4'b0000;
        run_nb    = 1'b0;
        digits_nb = 16'h0000;
`ifdef LEADING_ZERO_BLANK_EN
        lzm = 4'b1100;
`else
        lzm = 4'b0000;
`endif
        tick();
        tick();
        chk("rst_sel", 0, 32'(sel), 32'(0));
        chk("rst_sel_en", 0, 32'(sel_en), 32'(0));
        chk("rst_nibble", 0, 32'(nibble), 32'(0));
        chk("rst_dp", 0, 32'(dp), 32'(0));
        chk("rst_frame_done", 0, 32'(frame_done), 32'(0));
        reset = 1'b0;

        // Basic scan, then a mid-frame data change that must not tear.
        digits = 16'h1234;
        dp_in  = 4'b0010;
        run    = 1'b1;
        tick();
        check_frame(16'h1234, 4'b0010, 1'b0, -1, 16'h0000, 4'b0000);
        check_frame(16'h1234, 4'b0010, 1'b1, 7, 16'h5678, 4'b0000);
        check_frame(16'h5678, 4'b0010, 1'b1, -1, 16'h0000, 4'b0000);

        // Drop run while digit 2 is lit.
        repeat (12) tick();
        chk("pre_drop_sel", 12, 32'(sel), 32'(2));
        chk("pre_drop_sel_en", 12, 32'(sel_en), 32'(1));
        chk("pre_drop_nibble", 12, 32'(nibble), 32'(6));
        run    = 1'b0;
        digits = 16'h9ABC;
        dp_in  = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("drop_sel", k, 32'(sel), 32'(0));
            chk("drop_sel_en", k, 32'(sel_en), 32'(0));
            chk("drop_frame_done", k, 32'(frame_done), 32'(0));
        end
        run = 1'b1;
        tick();
        check_frame(16'h9ABC, 4'b1001, 1'b0, -1, 16'h0000, 4'b0000);
        chk("wrap_frame_done", 0, 32'(frame_done), 32'(1));
        chk("wrap_sel", 0, 32'(sel), 32'(0));
        chk("wrap_sel_en", 0, 32'(sel_en), 32'(1));

        // Asynchronous reset in digit 3's blank interval.
        repeat (22) tick();
        chk("pre_rst_sel", 22, 32'(sel), 32'(3));
        chk("pre_rst_sel_en", 22, 32'(sel_en), 32'(0));
        chk("pre_rst_nibble", 22, 32'(nibble), 32'(9));
        chk("pre_rst_dp", 22, 32'(dp), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_sel", 0, 32'(sel), 32'(0));
        chk("arst_sel_en", 0, 32'(sel_en), 32'(0));
        chk("arst_nibble", 0, 32'(nibble), 32'(0));
        chk("arst_dp", 0, 32'(dp), 32'(0));
        chk("arst_frame_done", 0, 32'(frame_done), 32'(0));
        tick();
        chk("arst_hold_frame_done", 1, 32'(frame_done), 32'(0));
        chk("arst_hold_sel_en", 1, 32'(sel_en), 32'(0));
        reset = 1'b0;
        tick();
        check_frame(16'h9ABC, 4'b1001, 1'b0, -1, 16'h0000, 4'b0000);

        // Leading zeros: shown by default, suppressed when the option is built in.
        run = 1'b0;
        tick();
        digits = 16'h0070;
        dp_in  = 4'b0000;
        run    = 1'b1;
        tick();
        check_frame(16'h0070, 4'b0000, 1'b0, -1, 16'h0000, lzm);
        chk("lz_period_frame_done", 24, 32'(frame_done), 32'(1));
        chk("lz_period_sel", 24, 32'(sel), 32'(0));
        chk("lz_period_sel_en", 24, 32'(sel_en), 32'(1));
        chk("lz_period_nibble", 24, 32'(nibble), 32'(0));

        // No blank interval: enable stays high, 16-cycle frame.
        digits_nb = 16'hABCD;
        run_nb    = 1'b1;
        tick();
        for (int k = 0; k < 32; k++) begin
            int s;
            s = (k / 4) % 4;
            chk("nb_sel", k, 32'(sel_nb), 32'(s));
            chk("nb_sel_en", k, 32'(sel_en_nb), 32'(1));
            chk("nb_nibble", k, 32'(nibble_nb), 32'(digits_nb[s*4 +: 4]));
            chk("nb_frame_done", k, 32'(frame_done_nb), (k == 16) ? 32'(1) : 32'(0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
